// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - MIPS register file with pending-writeback scoreboard (optional REGFILE_BYPASS_EN forwarding)
module register_file_sb #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_register,
    input  logic              flush,
    output logic              read_pending1,
    output logic              read_pending2,
    output logic              stall,
    output logic [ADDR_W:0]   pending_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [ADDR_W:0]     r_count;

    logic [NUM_REGS-1:0] w_pending_next;
    logic [ADDR_W:0]     w_count_next;
    logic                w_wb_en;
    logic                w_issue_en;
    logic [DATA_W-1:0]   w_stored1;
    logic [DATA_W-1:0]   w_stored2;
    logic                w_stored_pend1;
    logic                w_stored_pend2;

    // Register 0 is hardwired: writes and reservations aimed at it never take effect.
    assign w_wb_en    = RegWrite && (write_register != '0);
    assign w_issue_en = issue_valid && (issue_register != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else if (w_wb_en) begin
            r_regs[write_register] <= write_data;
        end
    end

    // Flush wins outright; otherwise a reservation overrides a writeback to the same register.
    always_comb begin
        w_pending_next = r_pending;
        if (flush) begin
            w_pending_next = '0;
        end else begin
            if (w_wb_en) begin
                w_pending_next[write_register] = 1'b0;
            end
            if (w_issue_en) begin
                w_pending_next[issue_register] = 1'b1;
            end
        end
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_count_next = w_count_next + {{ADDR_W{1'b0}}, w_pending_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_count   <= w_count_next;
        end
    end

    assign w_stored1      = (read_register1 == '0) ? '0 : r_regs[read_register1];
    assign w_stored2      = (read_register2 == '0) ? '0 : r_regs[read_register2];
    assign w_stored_pend1 = r_pending[read_register1];
    assign w_stored_pend2 = r_pending[read_register2];

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;
    logic w_issue_hit1;
    logic w_issue_hit2;

    assign w_fwd1       = w_wb_en && (write_register == read_register1);
    assign w_fwd2       = w_wb_en && (write_register == read_register2);
    assign w_issue_hit1 = w_issue_en && (issue_register == read_register1);
    assign w_issue_hit2 = w_issue_en && (issue_register == read_register2);

    // A forwarded value resolves the hazard unless the same register is being re-reserved now.
    assign read_data1    = w_fwd1 ? write_data : w_stored1;
    assign read_data2    = w_fwd2 ? write_data : w_stored2;
    assign read_pending1 = (w_fwd1 && !w_issue_hit1) ? 1'b0 : w_stored_pend1;
    assign read_pending2 = (w_fwd2 && !w_issue_hit2) ? 1'b0 : w_stored_pend2;
`else
    assign read_data1    = w_stored1;
    assign read_data2    = w_stored2;
    assign read_pending1 = w_stored_pend1;
    assign read_pending2 = w_stored_pend2;
`endif

    assign stall         = read_pending1 | read_pending2;
    assign pending_count = r_count;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb against a behavioural model
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_register1;
    logic [AW-1:0] read_register2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          issue_valid;
    logic [AW-1:0] issue_register;
    logic          flush;
    logic          read_pending1;
    logic          read_pending2;
    logic          stall;
    logic [AW:0]   pending_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];

    register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .RESET_VAL('0)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data),
        .read_register1(read_register1), .read_register2(read_register2),
        .read_data1(read_data1), .read_data2(read_data2),
        .issue_valid(issue_valid), .issue_register(issue_register), .flush(flush),
        .read_pending1(read_pending1), .read_pending2(read_pending2),
        .stall(stall), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += m_pend[i];
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && write_register == a) return write_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && write_register == a && !(issue_valid && issue_register == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    // Applies the clock-edge rules to the model using the inputs presented before the edge.
    task automatic tick();
        if (flush) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        end else begin
            if (RegWrite && write_register != 0) m_pend[write_register] = 1'b0;
            if (issue_valid && issue_register != 0) m_pend[issue_register] = 1'b1;
        end
        if (RegWrite && write_register != 0) m_regs[write_register] = write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; write_register = '0; write_data = '0;
        issue_valid = 1'b0; issue_register = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        read_register1 = 5'd19; read_register2 = 5'd26;
        model_reset();
        @(posedge clk); #2;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", read_data1, 32'h0); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", read_data2, 32'h0); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pending_count); end
        checks++; if ({read_pending1, read_pending2, stall} !== 3'b000) begin errors++; $display("FAIL reset_pend got %b exp 000", {read_pending1, read_pending2, stall}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; write_register = 5'd19; write_data = 32'h63636363;
        tick();
        write_register = 5'd26;
        tick();
        idle();
        read_register1 = 5'd26; read_register2 = 5'd19;
        #1;
        checks++; if (read_data1 !== 32'h63636363) begin errors++; $display("FAIL wr_r26 got %h exp %h", read_data1, 32'h63636363); end
        checks++; if (read_data2 !== 32'h63636363) begin errors++; $display("FAIL wr_r19 got %h exp %h", read_data2, 32'h63636363); end
        issue_valid = 1'b1; issue_register = 5'd4;
        tick();
        idle();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL pre_reset_count got %0d exp 1", pending_count); end
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL async_rst_rd1 got %h exp 0", read_data1); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL async_rst_rd2 got %h exp 0", read_data2); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", pending_count); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reg0();
        RegWrite = 1'b1; write_register = 5'd0; write_data = 32'hFFFFFFFF;
        tick();
        RegWrite = 1'b0; write_register = 5'd30; write_data = 32'hDEADBEEF;
        tick();
        idle();
        issue_valid = 1'b1; issue_register = 5'd0;
        tick();
        idle();
        read_register1 = 5'd0; read_register2 = 5'd30;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL r0_data got %h exp 0", read_data1); end
        checks++; if (read_pending1 !== 1'b0) begin errors++; $display("FAIL r0_pend got %b exp 0", read_pending1); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL r30_nowrite got %h exp 0", read_data2); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL r0_issue_count got %0d exp 0", pending_count); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_register = 5'd9;
        tick();
        idle();
        read_register1 = 5'd1; read_register2 = 5'd9;
        #1;
        checks++; if (read_pending2 !== 1'b1) begin errors++; $display("FAIL sb_pend2 got %b exp 1", read_pending2); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b exp 1", stall); end
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL sb_count got %0d exp 1", pending_count); end
        RegWrite = 1'b1; write_register = 5'd9; write_data = 32'h77777777;
        tick();
        idle();
        #1;
        checks++; if (read_pending2 !== 1'b0) begin errors++; $display("FAIL sb_wb_pend got %b exp 0", read_pending2); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL sb_wb_count got %0d exp 0", pending_count); end
        checks++; if (read_data2 !== 32'h77777777) begin errors++; $display("FAIL sb_wb_data got %h exp %h", read_data2, 32'h77777777); end
    endtask

    task automatic test_simultaneous();
        issue_valid = 1'b1; issue_register = 5'd5;
        tick();
        RegWrite = 1'b1; write_register = 5'd5; write_data = 32'h5A5A0005;
        tick();
        idle();
        read_register1 = 5'd5;
        #1;
        checks++; if (read_data1 !== 32'h5A5A0005) begin errors++; $display("FAIL sim_data got %h exp %h", read_data1, 32'h5A5A0005); end
        checks++; if (read_pending1 !== 1'b1) begin errors++; $display("FAIL sim_pend got %b exp 1", read_pending1); end
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL sim_count got %0d exp 1", pending_count); end
        issue_valid = 1'b1; issue_register = 5'd6; tick();
        issue_register = 5'd7; tick();
        checks++; if (pending_count !== 6'd3) begin errors++; $display("FAIL pre_flush_count got %0d exp 3", pending_count); end
        flush = 1'b1; issue_register = 5'd8;
        RegWrite = 1'b1; write_register = 5'd12; write_data = 32'hC0FFEE12;
        tick();
        idle();
        read_register1 = 5'd8; read_register2 = 5'd12;
        #1;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", pending_count); end
        checks++; if (read_pending1 !== 1'b0) begin errors++; $display("FAIL flush_r8 got %b exp 0", read_pending1); end
        checks++; if (read_data2 !== 32'hC0FFEE12) begin errors++; $display("FAIL flush_write got %h exp %h", read_data2, 32'hC0FFEE12); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_val;
        logic          same_pend;
        issue_valid = 1'b1; issue_register = 5'd3;
        tick();
        idle();
        old_val = m_regs[3];
        RegWrite = 1'b1; write_register = 5'd3; write_data = 32'h12345678;
        read_register1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        old_val = 32'h12345678;
        same_pend = 1'b0;
`else
        same_pend = 1'b1;
`endif
        checks++; if (read_data1 !== old_val) begin errors++; $display("FAIL byp_data got %h exp %h", read_data1, old_val); end
        checks++; if (read_pending1 !== same_pend) begin errors++; $display("FAIL byp_pend got %b exp %b", read_pending1, same_pend); end
        tick();
        idle();
        #1;
        checks++; if (read_data1 !== 32'h12345678) begin errors++; $display("FAIL byp_next got %h exp %h", read_data1, 32'h12345678); end
        checks++; if (read_pending1 !== 1'b0) begin errors++; $display("FAIL byp_next_pend got %b exp 0", read_pending1); end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        logic          p1, p2;
        for (int n = 0; n < 400; n++) begin
            RegWrite       = 1'($urandom_range(0, 1));
            write_register = AW'($urandom_range(0, NR - 1));
            write_data     = DW'($urandom);
            issue_valid    = 1'($urandom_range(0, 2) != 0);
            issue_register = AW'($urandom_range(0, NR - 1));
            flush          = ($urandom_range(0, 15) == 0);
            read_register1 = ($urandom_range(0, 3) == 0) ? write_register : AW'($urandom_range(0, NR - 1));
            read_register2 = AW'($urandom_range(0, NR - 1));
            #1;
            e1 = exp_data(read_register1); e2 = exp_data(read_register2);
            p1 = exp_pend(read_register1); p2 = exp_pend(read_register2);
            checks++; if (read_data1 !== e1) begin errors++; $display("FAIL rnd_rd1 n=%0d a=%0d got %h exp %h", n, read_register1, read_data1, e1); end
            checks++; if (read_data2 !== e2) begin errors++; $display("FAIL rnd_rd2 n=%0d a=%0d got %h exp %h", n, read_register2, read_data2, e2); end
            checks++; if ({read_pending1, read_pending2} !== {p1, p2}) begin errors++; $display("FAIL rnd_pend n=%0d got %b exp %b", n, {read_pending1, read_pending2}, {p1, p2}); end
            checks++; if (stall !== (p1 | p2)) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, stall, p1 | p2); end
            checks++; if (pending_count !== 6'(m_count())) begin errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, pending_count, m_count()); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        read_register1 = '0;
        read_register2 = '0;
        test_reset();
        test_write_read();
        test_reg0();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised register file for the MIPS datapath: 2 combinational read ports, 1 synchronous write port.
- Adds a per-register pending scoreboard. The decode stage reserves a destination register on issue; writeback releases it.
- Read ports return pending flags so hazard logic can stall.
- Supersedes the fixed 32x32 register file in the pipelined core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
RegWrite  input  1  writeback enable
write_register  input  ADDR_W  writeback destination
write_data  input  DATA_W  writeback data
read_register1  input  ADDR_W  read port 1 address
read_register2  input  ADDR_W  read port 2 address
read_data1  output  DATA_W  read port 1 data
read_data2  output  DATA_W  read port 2 data
issue_valid  input  1  reserve destination this cycle
issue_register  input  ADDR_W  destination to reserve
flush  input  1  synchronous clear of all pending bits
read_pending1  output  1  register at read_register1 awaits writeback
read_pending2  output  1  register at read_register2 awaits writeback
stall  output  1  read_pending1 | read_pending2
pending_count  output  ADDR_W+1  number of set pending bits (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers = RESET_VAL, except reg 0, which is always 0.
  - All pending bits = 0; pending_count = 0.
  - After reset, read_data1/2 reflect the stored values.
  - read_pending1/2 = 0 and stall = 0.
  - Reset mid-operation discards all state immediately.
- Register 0:
  - Reads always return 0 and are never pending.
  - Writes and issues targeting reg 0 are ignored and do not change pending_count.
- Write: on a rising edge with RegWrite=1 and write_register!=0, regs[write_register] <= write_data. RegWrite=0 leaves contents unchanged.
- Reads: combinational from the stored array. Without the feature, a write becomes visible the cycle after the edge.
- Pending bit update at each rising edge, in priority order:
  1. flush=1: all bits cleared; the issue this cycle is ignored; the write still occurs.
  2. Writeback (RegWrite=1, addr!=0): clears pending[write_register].
  3. Issue (issue_valid=1, addr!=0): sets pending[issue_register]. Issue beats writeback on the same address, so the bit ends at 1 and the data is still written.
- Issue to an already-pending register: the bit stays 1 and the count is unchanged.
- Writeback to a non-pending register: data is written and the count is unchanged.
- pending_count:
  - Equals the popcount of the pending vector after the edge.
  - Range 0..NUM_REGS-1; saturation is impossible because reg 0 is excluded.
  - Updated with the same latency as the pending bits.
- read_pending1/2: combinational from the registered pending bits and the read addresses.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - When RegWrite=1, write_register!=0 and write_register equals a read address, that read port returns write_data in the same cycle (write-first forwarding).
  - The matching read_pending is forced to 0 in that cycle unless issue_valid targets the same address in that cycle.
- Undefined: read ports show only stored values and registered pending bits, with no same-cycle forwarding.

Test Plan:
- Reset and write/read:
  - Reset, then write 0x63636363 to r19 and r26.
  - Read r26/r19 -> both 0x63636363 the cycle after the writes.
  - Assert rst=0 -> both reads 0 immediately, pending_count=0.
- Reg 0 and disabled write:
  - Write 0xFFFFFFFF to r0 -> r0 reads 0.
  - RegWrite=0 with r30 addressed -> r30 stays 0.
  - Issue r0 -> pending_count stays 0.
- Scoreboard hazard:
  - Issue r9, then read r9 -> read_pending2=1, stall=1, pending_count=1.
  - Writeback r9=0x77777777 -> next cycle pending=0, count=0, data=0x77777777.
- Simultaneous events:
  - Same-cycle issue r5 and writeback r5 -> r5 data updated, pending stays 1, count unchanged.
  - Issue r5, r6, r7, then flush together with issue r8 -> count=0 and r8 not pending.
- Bypass (REGFILE_BYPASS_EN):
  - Write 0x12345678 to r3 while reading r3 -> same-cycle read_data1=0x12345678, read_pending1=0.
  - With the macro undefined -> old value visible until the next cycle.
